// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer for the repeated-addition multiplier; optional ADD timeout via MUL_CTRL_TIMEOUT_EN
module mul_ctrl #(
  parameter int MAX_ITER = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqz,
  output logic ldA,
  output logic ldB,
  output logic ldP,
  output logic clrP,
  output logic decB,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic to;
`ifdef MUL_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign to = state_q == ADD && !eqz && cnt_q == 16'(MAX_ITER);
  // iteration counter and sticky timeout flag, cleared on the way back to IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= state_q == LOAD_B ? '0 : ldP ? cnt_q + 16'd1 : cnt_q;
      err   <= to | (err & state_d != IDLE);
    end
`else
  assign to  = 1'b0;
  assign err = 1'b0;
`endif
  assign ldP  = state_q == ADD && !eqz && !to;
  assign decB = ldP;
  // next state; unused encodings fall back to IDLE
  always_comb
    state_d = state_q == IDLE   ? (start ? LOAD_A : IDLE) :
              state_q == LOAD_A ? LOAD_B :
              state_q == LOAD_B ? ADD :
              state_q == ADD    ? (eqz || to ? DONE : ADD) :
              state_q == DONE   ? (start ? DONE : IDLE) : IDLE;
  // state register with Moore outputs registered from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ldA     <= 1'b0;
      ldB     <= 1'b0;
      clrP    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ldA     <= state_d == LOAD_A;
      ldB     <= state_d == LOAD_B;
      clrP    <= state_d == LOAD_B;
      busy    <= state_d != IDLE;
      done    <= state_d == DONE;
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: scoreboard bench driving mul_ctrl with a behavioural 16-bit datapath
module tb_mul_ctrl;
`ifdef MUL_CTRL_TIMEOUT_EN
  localparam int MI = 4;
  localparam bit TOE = 1'b1;
`else
  localparam int MI = 1024;
  localparam bit TOE = 1'b0;
`endif
  logic clk, rst, start, eqz;
  logic ldA, ldB, ldP, clrP, decB, busy, done, err;
  logic [15:0] op_a, op_b, din, pa, pb, pp;
  int errors = 0, checks = 0;
  typedef struct {logic [15:0] p; int n; int lat; logic e;} exp_t;
  exp_t q[$];

  mul_ctrl #(.MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .eqz(eqz),
    .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign din = ldA ? op_a : op_b;
  assign eqz = pb == 16'd0;
  always @(posedge clk)
    if (rst) begin
      pa <= '0;
      pb <= '0;
      pp <= '0;
    end else begin
      if (ldA) pa <= din;
      if (ldB) pb <= din;
      else if (decB) pb <= pb - 16'd1;
      if (clrP) pp <= '0;
      else if (ldP) pp <= pp + pa;
    end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [7:0] outs();
    return {ldA, ldB, ldP, clrP, decB, busy, done, err};
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit hold);
    exp_t x;
    x.n = (TOE && int'(b) > MI) ? MI : int'(b);
    x.p = 16'(int'(a) * x.n);
    x.lat = 4 + x.n;
    x.e = TOE && int'(b) > MI;
    q.push_back(x);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(negedge clk);
    start = hold;
  endtask

  task automatic finish_run(input string tag, input int rp, input bit hold);
    exp_t x;
    int pulses, lat, first, viol, bad;
    x = q.pop_front();
    pulses = 0; lat = 0; first = 0; viol = 0; bad = 0;
    for (int k = 1; k < 400; k++) begin
      if (k == 1) chk({tag, "_c1_ldA_busy"}, {31'd0, ldA & busy & !ldB}, 1);
      if (k == 2) chk({tag, "_c2_ldB_clrP"}, {31'd0, ldB & clrP & !ldA}, 1);
      if (int'(ldA) + int'(ldB) + int'(ldP) > 1 || decB !== ldP) viol++;
      if (ldP) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (k == rp) start = 1'b1;
      if (k == rp + 1) start = hold;
      @(negedge clk);
    end
    chk({tag, "_done_cycle"}, lat, x.lat);
    chk({tag, "_ldP_count"}, pulses, x.n);
    if (x.n > 0) chk({tag, "_first_ldP"}, first, 3);
    chk({tag, "_P"}, pp, x.p);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, x.e});
    chk({tag, "_onehot"}, viol, 0);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!done || !busy || ldA || ldB || ldP) bad++;
      end
      chk({tag, "_hold"}, bad, 0);
      start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_idle"}, {24'd0, outs()}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {24'd0, outs()}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {24'd0, outs()}, 0);
    launch(16'd5, 16'd3, 1'b0);
    finish_run("a5b3", 0, 1'b0);
    launch(16'd9, 16'd0, 1'b0);
    finish_run("b0", 0, 1'b0);
    launch(16'd3, 16'd2, 1'b1);
    finish_run("held", 0, 1'b1);
    launch(16'd7, 16'd4, 1'b0);
    finish_run("repulse", 4, 1'b0);
    launch(16'hFFFF, 16'd3, 1'b0);
    finish_run("wrap", 0, 1'b0);
    launch(16'd7, 16'd6, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_ldP", {31'd0, ldP}, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst", {24'd0, outs()}, 0);
    void'(q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    launch(16'd2, 16'd2, 1'b0);
    finish_run("after_rst", 0, 1'b0);
`ifdef MUL_CTRL_TIMEOUT_EN
    launch(16'd3, 16'd10, 1'b0);
    finish_run("timeout", 0, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
